// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Drains width_p-bit words from an upstream valid-yumi FIFO and packs pack_p
//   consecutive words into one wide beat. The beat is presented downstream on a
//   valid-ready interface. flush_i closes a partial beat early.
//
// Ports
//   clk_i    : clock, all state on posedge
//   reset_i  : synchronous active-high reset
//   valid_i  : upstream FIFO has a word
//   data_i   : upstream head word
//   yumi_o   : word consumed this cycle (combinational)
//   flush_i  : close the current partial beat
//   valid_o  : output beat held
//   data_o   : packed beat, word k in [k*width_p +: width_p], first word in the LSBs
//   count_o  : valid words in data_o
//   last_o   : beat was closed by flush_i
//   ready_i  : downstream accepts the beat
module fifo_word_packer #(
   parameter int unsigned width_p     = 8,
   parameter int unsigned pack_p      = 4,
   parameter int unsigned cnt_width_p = $clog2(pack_p + 1)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       valid_i,
   input  logic [width_p-1:0]         data_i,
   output logic                       yumi_o,
   input  logic                       flush_i,
   output logic                       valid_o,
   output logic [width_p*pack_p-1:0]  data_o,
   output logic [cnt_width_p-1:0]     count_o,
   output logic                       last_o,
   input  logic                       ready_i
);

   typedef enum logic [0:0] {StFill, StHold} state_e;

   localparam logic [cnt_width_p-1:0] LastIdx  = cnt_width_p'(pack_p - 1);
   localparam logic [cnt_width_p-1:0] FullCnt  = cnt_width_p'(pack_p);

   state_e                      state_q;
   logic [cnt_width_p-1:0]      idx_q;
   logic [width_p*pack_p-1:0]   data_q;
   logic [cnt_width_p-1:0]      count_q;
   logic                        last_q;

   logic [cnt_width_p-1:0]      fill_n;

   // In HOLD a word may only be taken when the held beat retires the same cycle.
   always_comb begin
      yumi_o = 1'b0;
      if (!reset_i && valid_i) begin
         yumi_o = (state_q == StFill) || ready_i;
      end
   end

   // Words in the beat if it were closed this cycle, including the same-cycle word.
   always_comb begin
      fill_n = idx_q + cnt_width_p'(yumi_o);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StFill;
         idx_q   <= '0;
         data_q  <= '0;
         count_q <= '0;
         last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StFill: begin
               if (yumi_o) begin
                  for (int k = 0; k < int'(pack_p); k++) begin
                     if (cnt_width_p'(k) == idx_q) begin
                        data_q[k*width_p +: width_p] <= data_i;
                     end
                  end
               end
               if (yumi_o && idx_q == LastIdx) begin
                  state_q <= StHold;
                  idx_q   <= '0;
                  count_q <= FullCnt;
                  last_q  <= flush_i;
               end else if (flush_i && fill_n != '0) begin
                  // Unused slots are already zero since retire/reset clears data_q.
                  state_q <= StHold;
                  idx_q   <= '0;
                  count_q <= fill_n;
                  last_q  <= 1'b1;
               end else if (yumi_o) begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            StHold: begin
               if (ready_i) begin
                  data_q  <= '0;
                  idx_q   <= '0;
                  last_q  <= 1'b0;
                  count_q <= '0;
                  state_q <= StFill;
                  if (yumi_o) begin
                     data_q[width_p-1:0] <= data_i;
                     if (pack_p == 1) begin
                        // Single-word beats: the new word is immediately a full beat.
                        state_q <= StHold;
                        count_q <= FullCnt;
                     end else begin
                        idx_q <= cnt_width_p'(1);
                     end
                  end
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

   assign valid_o = (state_q == StHold);
   assign data_o  = data_q;
   assign count_o = count_q;
   assign last_o  = last_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
//   Directed self-checking bench for fifo_word_packer (width_p=8, pack_p=4).
//   Inputs are driven on the falling edge; yumi_o is sampled 1 ns later and
//   registered outputs 1 ns after the following rising edge.
module tb_fifo_word_packer;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        valid_i;
   logic [7:0]  data_i;
   logic        yumi_o;
   logic        flush_i;
   logic        valid_o;
   logic [31:0] data_o;
   logic [2:0]  count_o;
   logic        last_o;
   logic        ready_i;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic        yumi_s;

   always #5 clk_i = ~clk_i;

   fifo_word_packer #(
      .width_p (8),
      .pack_p  (4)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (valid_i),
      .data_i  (data_i),
      .yumi_o  (yumi_o),
      .flush_i (flush_i),
      .valid_o (valid_o),
      .data_o  (data_o),
      .count_o (count_o),
      .last_o  (last_o),
      .ready_i (ready_i)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, capture yumi_o, let the edge happen.
   task automatic cyc(input logic rst, input logic v, input logic [7:0] d,
                      input logic f, input logic r);
      @(negedge clk_i);
      reset_i = rst;
      valid_i = v;
      data_i  = d;
      flush_i = f;
      ready_i = r;
      #1;
      yumi_s = yumi_o;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_beat(input string tag, input logic [31:0] d, input logic [2:0] c,
                             input logic l);
      check({tag, ".valid"}, 64'(valid_o), 64'(1'b1));
      check({tag, ".data"},  64'(data_o),  64'(d));
      check({tag, ".count"}, 64'(count_o), 64'(c));
      check({tag, ".last"},  64'(last_o),  64'(l));
   endtask

   initial begin
      logic [7:0]  w1 [4];
      logic [31:0] held;
      w1[0] = 8'h11; w1[1] = 8'h22; w1[2] = 8'h33; w1[3] = 8'h44;

      // Test 1: reset, then a full beat.
      cyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
      check("rst.yumi", 64'(yumi_s), 64'(1'b0));
      cyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
      check("rst.valid", 64'(valid_o), 64'(1'b0));
      check("rst.data",  64'(data_o),  64'(0));
      check("rst.count", 64'(count_o), 64'(0));
      check("rst.last",  64'(last_o),  64'(1'b0));
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, w1[i], 1'b0, 1'b1);
         check($sformatf("t1.yumi%0d", i), 64'(yumi_s), 64'(1'b1));
         if (i < 3) check($sformatf("t1.novalid%0d", i), 64'(valid_o), 64'(1'b0));
      end
      check_beat("t1", 32'h44332211, 3'd4, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("t1.retire.valid", 64'(valid_o), 64'(1'b0));
      check("t1.retire.data",  64'(data_o),  64'(0));

      // Test 2: flush after two words, then flush coinciding with the second word.
      cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
      check("t2a.novalid", 64'(valid_o), 64'(1'b0));
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("t2a.yumi", 64'(yumi_s), 64'(1'b0));
      check_beat("t2a", 32'h0000BBAA, 3'd2, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("t2a.retire", 64'(valid_o), 64'(1'b0));
      cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
      check_beat("t2b", 32'h0000BBAA, 3'd2, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Test 3: backpressure holds the beat; release takes the waiting word into slot 0.
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
      check_beat("t3", 32'h04030201, 3'd4, 1'b0);
      held = data_o;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
         check($sformatf("t3.yumi%0d", i), 64'(yumi_s), 64'(1'b0));
         check($sformatf("t3.data%0d", i), 64'(data_o), 64'(32'h04030201));
         check($sformatf("t3.count%0d", i), 64'(count_o), 64'(3'd4));
      end
      check("t3.held", 64'(data_o), 64'(held));
      cyc(1'b0, 1'b1, 8'h66, 1'b0, 1'b1);
      check("t3.rel.yumi",  64'(yumi_s),  64'(1'b1));
      check("t3.rel.valid", 64'(valid_o), 64'(1'b0));
      check("t3.rel.data",  64'(data_o),  64'(32'h00000066));
      cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 8'h88, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
      check_beat("t3.next", 32'h99887766, 3'd4, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Test 4: 12-word continuous stream, three beats with overlap in HOLD.
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
         check($sformatf("t4.yumi%0d", i), 64'(yumi_s), 64'(1'b1));
         if (i % 4 == 3) begin
            check_beat($sformatf("t4.beat%0d", i / 4),
                       {8'(8'h10 + i), 8'(8'h0F + i), 8'(8'h0E + i), 8'(8'h0D + i)},
                       3'd4, 1'b0);
         end else begin
            check($sformatf("t4.novalid%0d", i), 64'(valid_o), 64'(1'b0));
         end
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("t4.retire", 64'(valid_o), 64'(1'b0));

      // Test 5: empty flush emits nothing; reset mid-beat discards the partial words.
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check("t5.noempty", 64'(valid_o), 64'(1'b0));
      cyc(1'b0, 1'b1, 8'hA1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 8'hA2, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 8'hA3, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 8'hA4, 1'b0, 1'b1);
      check("t5.rst.yumi",  64'(yumi_s),  64'(1'b0));
      check("t5.rst.valid", 64'(valid_o), 64'(1'b0));
      check("t5.rst.data",  64'(data_o),  64'(0));
      cyc(1'b0, 1'b1, 8'hB1, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 8'hB2, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 8'hB3, 1'b0, 1'b1);
      check("t5.novalid", 64'(valid_o), 64'(1'b0));
      cyc(1'b0, 1'b1, 8'hB4, 1'b0, 1'b1);
      check_beat("t5", 32'hB4B3B2B1, 3'd4, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
